byte_block_packer: RTL
======================

BYTE_BLOCK_PACKER -- requirements
Module: byte_block_packer

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 10000: sys_clk cycles allowed between bytes of a partial block; used only when PACKER_TIMEOUT_EN is defined.
REQ-002 sys_clk  input  1  single clock for all state.
REQ-003 sys_rst_l  input  1  reset, asynchronous, active-low.
REQ-004 rec_dataH  input  8  received byte from the UART receiver.
REQ-005 rec_readyH  input  1  receiver byte-ready level; a rising edge marks a new byte.
REQ-006 blk_dataH  output  64  assembled block, first received byte in [63:56].
REQ-007 blk_validH  output  1  block available to the TDES core.
REQ-008 blk_readyH  input  1  TDES core accepts the block.
REQ-009 byte_cntH  output  3  bytes collected in the current partial block (0-7).
REQ-010 clr_errH  input  1  synchronous clear of the sticky error flags.
REQ-011 overrunH  output  1  sticky flag: a byte was dropped.
REQ-012 timeoutH  output  1  sticky flag: a partial block was discarded on timeout.

Function
REQ-013 The block SHALL register rec_readyH each cycle; strobe = rec_readyH AND NOT registered value.
REQ-014 The block SHALL have two states: COLLECT (blk_validH=0) and HOLD (blk_validH=1).
REQ-015 In COLLECT, on a strobe edge the block SHALL shift rec_dataH into blk_dataH at the byte position given by byte_cntH, MSB first, and increment byte_cntH.
REQ-016 On the edge capturing the eighth byte, the block SHALL enter HOLD, assert blk_validH and wrap byte_cntH to 0 (zero added latency).
REQ-017 In HOLD, blk_dataH SHALL stay stable until blk_validH AND blk_readyH; that edge returns the block to COLLECT with blk_validH=0.
REQ-018 A strobe in HOLD without blk_readyH SHALL drop the byte, leave blk_dataH unchanged and set overrunH.
REQ-019 A strobe on the same edge as a handshake SHALL be captured as byte 0 of the next block; overrunH SHALL NOT be set.
REQ-020 blk_readyH SHALL be ignored in COLLECT.
REQ-021 clr_errH SHALL clear overrunH and timeoutH; if a set condition occurs on the same edge, set wins.
REQ-022 rec_readyH held high SHALL produce exactly one capture.

Reset
REQ-023 Asserting sys_rst_l low SHALL immediately force COLLECT, blk_dataH=0, blk_validH=0, byte_cntH=0, overrunH=0, timeoutH=0, and clear the edge register and timeout counter.
REQ-024 Reset mid-block or in HOLD SHALL discard all partial or pending data; the first strobe after release is byte 0.

Configuration
REQ-025 With PACKER_TIMEOUT_EN defined: a counter SHALL clear on each strobe and increment in COLLECT while byte_cntH != 0. When it reaches TIMEOUT_CYCLES, byte_cntH SHALL return to 0, the partial data SHALL be discarded and timeoutH SHALL be set. A strobe on that same edge SHALL be captured as byte 0.
REQ-026 Without PACKER_TIMEOUT_EN: no counter SHALL exist, timeoutH SHALL be tied to 0, and partial blocks SHALL be held indefinitely.

Verification
REQ-027 Bytes 88,89,88,89,01,00,00,00 -> blk_validH rises on the eighth capture edge, blk_dataH=64'h8889888901000000, byte_cntH=0.
REQ-028 Block pending with blk_readyH=0 and byte 0x55 sent -> overrunH=1, blk_dataH unchanged; clr_errH pulse -> overrunH=0.
REQ-029 Handshake and strobe of 0xA5 on the same edge -> blk_validH=0, byte_cntH=1, blk_dataH[63:56]=8'hA5, overrunH=0.
REQ-030 sys_rst_l pulsed low after 3 bytes -> all outputs 0 asynchronously; 8 new bytes form a complete block.
REQ-031 With PACKER_TIMEOUT_EN and TIMEOUT_CYCLES=50: 2 bytes, then 50 idle cycles -> byte_cntH=0, timeoutH=1. Without the macro: byte_cntH stays 2, timeoutH=0.
REQ-032 rec_readyH held high for 20 cycles with rec_dataH=0x3C -> byte_cntH increments by exactly 1.

Source files
------------

// File: rtl/byte_block_packer.sv
// byte_block_packer
//   Packs bytes from a UART receiver into 64-bit blocks for a TDES core.
//   The first byte received lands in blk_dataH[63:56]. A finished block is
//   held with blk_validH=1 until blk_readyH is seen.
//
// Ports
//   sys_clk     in   clock for all state
//   sys_rst_l   in   asynchronous active-low reset
//   rec_dataH   in   [7:0]  received byte
//   rec_readyH  in   receiver byte-ready level (rising edge = new byte)
//   blk_dataH   out  [63:0] assembled block
//   blk_validH  out  block available
//   blk_readyH  in   consumer accepts block (only looked at while holding)
//   byte_cntH   out  [2:0]  bytes in the current partial block
//   clr_errH    in   synchronous clear of the sticky error flags
//   overrunH    out  sticky: a byte arrived while a block was pending
//   timeoutH    out  sticky: a partial block was abandoned
//
// Build option
//   PACKER_TIMEOUT_EN : when defined, a partial block that receives no byte
//   for TIMEOUT_CYCLES clocks is discarded and timeoutH is set. When not
//   defined there is no counter and timeoutH is constant 0.
module byte_block_packer #(
  parameter int unsigned TIMEOUT_CYCLES = 10000
) (
  input  logic        sys_clk,
  input  logic        sys_rst_l,
  input  logic [7:0]  rec_dataH,
  input  logic        rec_readyH,
  output logic [63:0] blk_dataH,
  output logic        blk_validH,
  input  logic        blk_readyH,
  output logic [2:0]  byte_cntH,
  input  logic        clr_errH,
  output logic        overrunH,
  output logic        timeoutH
);

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } state_e;

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  state_e      state_q, state_d;
  logic [63:0] data_q, data_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        ovr_q, ovr_d;
  logic        rdy_q;
  logic        strobe;
  logic        tmo_hit;
  logic [2:0]  eff_cnt;

  assign strobe = rec_readyH & ~rdy_q;

  // A timeout and a strobe on the same edge: the partial block is dropped
  // first, so the new byte is treated as byte 0.
  assign eff_cnt = tmo_hit ? 3'd0 : cnt_q;

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    ovr_d   = clr_errH ? 1'b0 : ovr_q;
    unique case (state_q)
      COLLECT: begin
        if (tmo_hit) begin
          cnt_d  = '0;
          data_d = '0;
        end
        if (strobe) begin
          if (eff_cnt == 3'd0) begin
            data_d = {rec_dataH, 56'd0};
          end else begin
            // byte k sits at bits [8*(7-k)+7 : 8*(7-k)]; 7-k == ~k in 3 bits
            data_d[{~eff_cnt, 3'b000} +: 8] = rec_dataH;
          end
          if (eff_cnt == 3'd7) begin
            state_d = HOLD;
            cnt_d   = '0;
          end else begin
            cnt_d = eff_cnt + 3'd1;
          end
        end
      end
      HOLD: begin
        if (blk_readyH) begin
          state_d = COLLECT;
          if (strobe) begin
            data_d = {rec_dataH, 56'd0};
            cnt_d  = 3'd1;
          end
        end else if (strobe) begin
          ovr_d = 1'b1;
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_l) begin
    if (!sys_rst_l) begin
      state_q <= COLLECT;
      data_q  <= '0;
      cnt_q   <= '0;
      ovr_q   <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      ovr_q   <= ovr_d;
      rdy_q   <= rec_readyH;
    end
  end

`ifdef PACKER_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] tcnt_q, tcnt_d;
  logic          tflag_q, tflag_d;

  // Fires on the edge at which the idle count would reach TIMEOUT_CYCLES.
  assign tmo_hit = (state_q == COLLECT) && (cnt_q != 3'd0) &&
                   (tcnt_q == TW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    tcnt_d = tcnt_q;
    if ((state_q != COLLECT) || (cnt_q == 3'd0) || strobe || tmo_hit) begin
      tcnt_d = '0;
    end else begin
      tcnt_d = tcnt_q + 1'b1;
    end
    tflag_d = clr_errH ? 1'b0 : tflag_q;
    if (tmo_hit) begin
      tflag_d = 1'b1;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_l) begin
    if (!sys_rst_l) begin
      tcnt_q  <= '0;
      tflag_q <= 1'b0;
    end else begin
      tcnt_q  <= tcnt_d;
      tflag_q <= tflag_d;
    end
  end

  assign timeoutH = tflag_q;
`else
  assign tmo_hit  = 1'b0;
  assign timeoutH = 1'b0;
`endif

  assign blk_dataH  = data_q;
  assign blk_validH = (state_q == HOLD);
  assign byte_cntH  = cnt_q;
  assign overrunH   = ovr_q;

endmodule
